// File: rtl/add8u_err_monitor.sv
// Streaming error-metric engine for 8-bit unsigned approximate adders.
// It recomputes a+b, measures |exact-approx| and accumulates the MAE/MSE numerators, the EP count and the WCE.
module add8u_err_monitor #(
    parameter int CNT_W = 32,
    parameter int SUM_W = 48,
    parameter int SQ_W  = 56
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             clear,
    input  logic [CNT_W-1:0] n_samples,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       a,
    input  logic [7:0]       b,
    input  logic [8:0]       approx_sum,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] sample_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [SUM_W-1:0] abs_err_sum,
    output logic [SQ_W-1:0]  sq_err_sum,
    output logic [8:0]       wce
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state;
    logic [CNT_W-1:0]  target;
    logic [CNT_W-1:0]  accepted;
    logic [CNT_W-1:0]  accepted_nxt;
    logic              hs_p0;
    logic              start_ok;
    logic [8:0]        exact_p0;
    logic signed [9:0] diff_p0;
    logic [8:0]        err_p0;
    logic              vld_p1;
    logic [8:0]        err_p1;
    logic              nz_p1;
    logic [17:0]       sq_p1;

    function automatic logic [8:0] abs_err(input logic signed [9:0] d);
        logic signed [9:0] m;
        m = (d < 0) ? -d : d;
        return m[8:0];
    endfunction

    function automatic logic [CNT_W-1:0] sat_cnt(input logic [CNT_W-1:0] acc,
                                                 input logic [CNT_W-1:0] inc);
        logic [CNT_W:0] s;
        s = {1'b0, acc} + {1'b0, inc};
        return s[CNT_W] ? '1 : s[CNT_W-1:0];
    endfunction

    function automatic logic [SUM_W-1:0] sat_sum(input logic [SUM_W-1:0] acc,
                                                 input logic [SUM_W-1:0] inc);
        logic [SUM_W:0] s;
        s = {1'b0, acc} + {1'b0, inc};
        return s[SUM_W] ? '1 : s[SUM_W-1:0];
    endfunction

    function automatic logic [SQ_W-1:0] sat_sq(input logic [SQ_W-1:0] acc,
                                               input logic [SQ_W-1:0] inc);
        logic [SQ_W:0] s;
        s = {1'b0, acc} + {1'b0, inc};
        return s[SQ_W] ? '1 : s[SQ_W-1:0];
    endfunction

    function automatic logic [8:0] max9(input logic [8:0] x, input logic [8:0] y);
        return (x > y) ? x : y;
    endfunction

    assign hs_p0        = in_valid && in_ready;
    assign start_ok     = start && (state != RUN);
    assign accepted_nxt = accepted + CNT_W'(1);

    // Stage 0: exact sum and absolute error, combinational from the accepted inputs
    assign exact_p0 = {1'b0, a} + {1'b0, b};
    assign diff_p0  = $signed({1'b0, exact_p0}) - $signed({1'b0, approx_sum});
    assign err_p0   = abs_err(diff_p0);

    // Run control; in_ready is kept registered as (state==RUN && accepted<target)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            target   <= '0;
            accepted <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else if (clear) begin
            state    <= IDLE;
            target   <= '0;
            accepted <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        target   <= n_samples;
                        accepted <= '0;
                        if (n_samples == '0) begin
                            state    <= DONE;
                            in_ready <= 1'b0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                        end else begin
                            state    <= RUN;
                            in_ready <= 1'b1;
                            busy     <= 1'b1;
                            done     <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    if (hs_p0) begin
                        accepted <= accepted_nxt;
                        in_ready <= (accepted_nxt < target);
                    end
                    // No handshake is possible once accepted==target, so stage 1 drains on this edge
                    if (accepted == target) begin
                        state    <= DONE;
                        in_ready <= 1'b0;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                end
            endcase
        end
    end

    // Stage 1: capture error of the accepted sample
    always_ff @(posedge clk) begin
        if (hs_p0) begin
            err_p1 <= err_p0;
            nz_p1  <= (err_p0 != '0);
        end
    end

    assign sq_p1 = {9'd0, err_p1} * {9'd0, err_p1};

    // Stage 2: saturating accumulation into the visible statistics
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1      <= 1'b0;
            sample_cnt  <= '0;
            err_cnt     <= '0;
            abs_err_sum <= '0;
            sq_err_sum  <= '0;
            wce         <= '0;
        end else if (clear) begin
            vld_p1      <= 1'b0;
            sample_cnt  <= '0;
            err_cnt     <= '0;
            abs_err_sum <= '0;
            sq_err_sum  <= '0;
            wce         <= '0;
        end else begin
            vld_p1 <= hs_p0;
            if (start_ok) begin
                sample_cnt  <= '0;
                err_cnt     <= '0;
                abs_err_sum <= '0;
                sq_err_sum  <= '0;
                wce         <= '0;
            end else if (vld_p1) begin
                sample_cnt  <= sat_cnt(sample_cnt, CNT_W'(1));
                err_cnt     <= sat_cnt(err_cnt, CNT_W'(nz_p1));
                abs_err_sum <= sat_sum(abs_err_sum, SUM_W'(err_p1));
                sq_err_sum  <= sat_sq(sq_err_sum, SQ_W'(sq_p1));
                wce         <= max9(wce, err_p1);
            end
        end
    end

endmodule

// File: tb/tb_add8u_err_monitor.sv
// Bench for add8u_err_monitor: table-driven runs, a per-cycle queue scoreboard and hand-written corner sequences.
module tb_add8u_err_monitor;
    localparam int CNT_W  = 32;
    localparam int SUM_W  = 48;
    localparam int SQ_W   = 56;
    localparam int SSUM_W = 12;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic             clear;
    logic [CNT_W-1:0] n_samples;
    logic             in_valid;
    logic [7:0]       a;
    logic [7:0]       b;
    logic [8:0]       approx_sum;

    logic              in_ready, busy, done;
    logic [CNT_W-1:0]  sample_cnt, err_cnt;
    logic [SUM_W-1:0]  abs_err_sum;
    logic [SQ_W-1:0]   sq_err_sum;
    logic [8:0]        wce;

    logic              s_in_ready, s_busy, s_done;
    logic [CNT_W-1:0]  s_sample_cnt, s_err_cnt;
    logic [SSUM_W-1:0] s_abs_err_sum;
    logic [SQ_W-1:0]   s_sq_err_sum;
    logic [8:0]        s_wce;

    add8u_err_monitor #(.CNT_W(CNT_W), .SUM_W(SUM_W), .SQ_W(SQ_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .clear(clear), .n_samples(n_samples),
        .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .approx_sum(approx_sum),
        .busy(busy), .done(done), .sample_cnt(sample_cnt), .err_cnt(err_cnt),
        .abs_err_sum(abs_err_sum), .sq_err_sum(sq_err_sum), .wce(wce)
    );

    add8u_err_monitor #(.CNT_W(CNT_W), .SUM_W(SSUM_W), .SQ_W(SQ_W)) dut_s (
        .clk(clk), .rst_n(rst_n), .start(start), .clear(clear), .n_samples(n_samples),
        .in_valid(in_valid), .in_ready(s_in_ready), .a(a), .b(b), .approx_sum(approx_sum),
        .busy(s_busy), .done(s_done), .sample_cnt(s_sample_cnt), .err_cnt(s_err_cnt),
        .abs_err_sum(s_abs_err_sum), .sq_err_sum(s_sq_err_sum), .wce(s_wce)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [8:0] s;
    } smp_t;

    typedef struct {
        int     first;
        int     n;
        longint abs_e;
        longint sq_e;
        int     wce_e;
        int     err_e;
    } run_t;

    smp_t smp [0:13];
    run_t runs [0:4];

    int checks   = 0;
    int failures = 0;

    int     q[$];
    longint m_cnt, m_err, m_abs, m_sq, m_wce;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int err_of(input logic [7:0] x, input logic [7:0] y, input logic [8:0] s);
        int e;
        e = int'(x) + int'(y) - int'(s);
        return (e < 0) ? -e : e;
    endfunction

    // Scoreboard: errors queued at the accepting edge, folded into the model one edge later
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt = 0; m_err = 0; m_abs = 0; m_sq = 0; m_wce = 0;
            q.delete();
        end else begin
            check("sb_sample_cnt", longint'(sample_cnt), m_cnt);
            check("sb_err_cnt", longint'(err_cnt), m_err);
            check("sb_abs_err_sum", longint'(abs_err_sum), m_abs);
            check("sb_sq_err_sum", longint'(sq_err_sum), m_sq);
            check("sb_wce", longint'(wce), m_wce);
            if (clear || start) begin
                m_cnt = 0; m_err = 0; m_abs = 0; m_sq = 0; m_wce = 0;
                q.delete();
            end else if (q.size() > 0) begin
                int e;
                e = q.pop_front();
                m_cnt++;
                if (e != 0) m_err++;
                m_abs += e;
                m_sq  += longint'(e) * longint'(e);
                if (e > m_wce) m_wce = e;
            end
            if (in_valid && in_ready && !clear)
                q.push_back(err_of(a, b, approx_sum));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int n);
        n_samples = CNT_W'(n);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input smp_t v);
        bit ok;
        ok = 1'b0;
        a = v.a; b = v.b; approx_sum = v.s;
        in_valid = 1'b1;
        for (int t = 0; t < 50 && !ok; t++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                tick();
            end
        end
        in_valid = 1'b0;
        check("send_handshake", longint'(ok), 1);
    endtask

    task automatic wait_done();
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 30 && !ok; t++) begin
            @(negedge clk);
            if (done) ok = 1'b1;
        end
        check("done_seen", longint'(ok), 1);
    endtask

    initial begin
        int   hs;
        int   idx;
        bit   rdy_seen;
        smp_t v;
        smp_t junk;

        smp[0]  = '{8'd0,   8'd0,   9'd0};
        smp[1]  = '{8'd255, 8'd255, 9'd510};
        smp[2]  = '{8'd1,   8'd2,   9'd3};
        smp[3]  = '{8'd128, 8'd128, 9'd256};
        smp[4]  = '{8'd100, 8'd50,  9'd134};
        smp[5]  = '{8'd10,  8'd20,  9'd27};
        smp[6]  = '{8'd40,  8'd2,   9'd47};
        smp[7]  = '{8'd7,   8'd8,   9'd15};
        smp[8]  = '{8'd255, 8'd255, 9'd0};
        smp[9]  = '{8'd200, 8'd100, 9'd256};
        smp[10] = '{8'd3,   8'd3,   9'd511};
        smp[11] = '{8'd0,   8'd0,   9'd1};
        smp[12] = '{8'd255, 8'd0,   9'd255};
        smp[13] = '{8'd50,  8'd60,  9'd100};
        runs[0] = '{0, 4, 0,   0,      0,   0};
        runs[1] = '{4, 1, 16,  256,    16,  1};
        runs[2] = '{5, 3, 8,   34,     5,   2};
        runs[3] = '{8, 1, 510, 260100, 510, 1};
        runs[4] = '{9, 5, 560, 257062, 505, 4};
        junk    = '{8'd9, 8'd9, 9'd0};

        rst_n = 1'b0; start = 1'b0; clear = 1'b0; n_samples = '0;
        in_valid = 1'b0; a = '0; b = '0; approx_sum = '0;
        #12;
        check("rst_in_ready", longint'(in_ready), 0);
        check("rst_busy", longint'(busy), 0);
        check("rst_done", longint'(done), 0);
        check("rst_sample_cnt", longint'(sample_cnt), 0);
        check("rst_abs", longint'(abs_err_sum), 0);
        check("rst_wce", longint'(wce), 0);
        rst_n = 1'b1;
        tick();

        for (int r = 0; r < 5; r++) begin
            do_start(runs[r].n);
            check("run_busy", longint'(busy), 1);
            for (int i = 0; i < runs[r].n; i++) send(smp[runs[r].first + i]);
            wait_done();
            check("run_done", longint'(done), 1);
            check("run_sample_cnt", longint'(sample_cnt), longint'(runs[r].n));
            check("run_err_cnt", longint'(err_cnt), longint'(runs[r].err_e));
            check("run_abs", longint'(abs_err_sum), runs[r].abs_e);
            check("run_sq", longint'(sq_err_sum), runs[r].sq_e);
            check("run_wce", longint'(wce), longint'(runs[r].wce_e));
        end

        // Backpressure: in_valid held for five cycles against a three-sample run
        do_start(3);
        hs = 0; idx = 0;
        in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            v = (idx < 3) ? smp[runs[2].first + idx] : junk;
            a = v.a; b = v.b; approx_sum = v.s;
            @(negedge clk);
            if (in_ready) begin
                hs++;
                idx++;
            end
            tick();
        end
        in_valid = 1'b0;
        check("bp_handshakes", longint'(hs), 3);
        check("bp_in_ready_low", longint'(in_ready), 0);
        wait_done();
        check("bp_abs", longint'(abs_err_sum), 8);
        check("bp_sq", longint'(sq_err_sum), 34);
        check("bp_wce", longint'(wce), 5);
        check("bp_err_cnt", longint'(err_cnt), 2);

        // Clear with a handshake in the clear cycle and one sample still in stage 1
        do_start(10);
        for (int i = 0; i < 4; i++) send(smp[9 + i]);
        check("clr_pre_cnt", longint'(sample_cnt), 3);
        a = 8'd3; b = 8'd3; approx_sum = 9'd511;
        in_valid = 1'b1;
        clear = 1'b1;
        check("clr_hs_offered", longint'(in_ready), 1);
        tick();
        clear = 1'b0;
        in_valid = 1'b0;
        check("clr_busy", longint'(busy), 0);
        check("clr_done", longint'(done), 0);
        check("clr_in_ready", longint'(in_ready), 0);
        tick(); tick();
        check("clr_sample_cnt", longint'(sample_cnt), 0);
        check("clr_abs", longint'(abs_err_sum), 0);
        check("clr_wce", longint'(wce), 0);

        // Zero-length run
        do_start(0);
        check("zero_done", longint'(done), 1);
        check("zero_busy", longint'(busy), 0);
        rdy_seen = in_ready;
        for (int c = 0; c < 3; c++) begin
            tick();
            rdy_seen = rdy_seen | in_ready;
        end
        check("zero_in_ready_never", longint'(rdy_seen), 0);
        check("zero_done_held", longint'(done), 1);
        check("zero_sample_cnt", longint'(sample_cnt), 0);

        // Worst-case error repeated until the narrow accumulator saturates
        do_start(10);
        for (int i = 0; i < 10; i++) send(smp[8]);
        wait_done();
        check("sat_wce", longint'(wce), 510);
        check("sat_err_cnt", longint'(err_cnt), 10);
        check("sat_abs_wide", longint'(abs_err_sum), 5100);
        check("sat_sq_wide", longint'(sq_err_sum), 2601000);
        check("sat_done_narrow", longint'(s_done), 1);
        check("sat_abs_narrow", longint'(s_abs_err_sum), 4095);
        check("sat_sq_narrow", longint'(s_sq_err_sum), 2601000);

        // Asynchronous reset with samples in flight
        do_start(6);
        for (int i = 0; i < 3; i++) send(smp[9 + i]);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", longint'(busy), 0);
        check("arst_done", longint'(done), 0);
        check("arst_in_ready", longint'(in_ready), 0);
        check("arst_sample_cnt", longint'(sample_cnt), 0);
        check("arst_err_cnt", longint'(err_cnt), 0);
        check("arst_abs", longint'(abs_err_sum), 0);
        check("arst_sq", longint'(sq_err_sum), 0);
        check("arst_wce", longint'(wce), 0);
        #3;
        rst_n = 1'b1;
        tick(); tick();
        check("post_rst_busy", longint'(busy), 0);
        check("post_rst_in_ready", longint'(in_ready), 0);
        check("post_rst_done", longint'(done), 0);
        check("post_rst_sample_cnt", longint'(sample_cnt), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
